// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential multiplier and its downstream
// dot-product accumulator: accumulator state encoding, the default operand
// width and the derived product width.
// -----------------------------------------------------------------------------
package mult_pkg;

    // Multiplier operand width shared by the multiplier and its consumers.
    localparam int L_WORD_DEF = 4;

    // Products are twice the operand width.
    function automatic int prod_width(input int l_word);
        return 2 * l_word;
    endfunction

    localparam int PROD_W_DEF = prod_width(L_WORD_DEF);

    // Accumulator FSM: ACCUM sums products, HOLD presents a finished result.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

endpackage : mult_pkg

// File: rtl/ready_edge_detect.sv
// -----------------------------------------------------------------------------
// ready_edge_detect
// Turns the multiplier's level Ready flag into a one-cycle completion strobe.
// The history register resets to 1 so that a Ready held high through reset
// (the multiplier's idle/reset state) is never mistaken for a completion.
//
// Ports:
//   clk      in  : clock, rising edge
//   rst      in  : synchronous active-high reset
//   ready_i  in  : multiplier Ready flag
//   cmpl_o   out : high for the cycle in which Ready is first seen high
// -----------------------------------------------------------------------------
module ready_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic ready_i,
    output logic cmpl_o
);

    logic rdy_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q <= 1'b1;
        end else begin
            rdy_q <= ready_i;
        end
    end

    assign cmpl_o = ready_i & ~rdy_q;

endmodule : ready_edge_detect

// File: rtl/mult_dot_accumulator.sv
// -----------------------------------------------------------------------------
// mult_dot_accumulator
// Sums N_TERMS consecutive multiplier products into a dot-product result and
// presents it on a valid/ack handshake. A one-entry pending buffer absorbs a
// product that completes while the previous result is still waiting for ack,
// so the multiplier never stalls.
//
// Ports:
//   clk            in  : clock, rising edge
//   rst            in  : synchronous active-high reset
//   Ready          in  : multiplier ready flag (0->1 marks a completed product)
//   final_product  in  : multiplier result, valid when Ready is first seen high
//   clear          in  : synchronous abort of the current accumulation
//   acc_ack        in  : consumer accepts acc_out
//   acc_out        out : dot-product result, stable while acc_valid
//   acc_valid      out : result available
//   term_count     out : products accumulated in the current sum
//   overflow       out : sticky, accumulator wrapped
//   overrun        out : sticky, a product was dropped
//   busy           out : term_count != 0 or acc_valid
// -----------------------------------------------------------------------------
module mult_dot_accumulator
    import mult_pkg::*;
#(
    parameter int L_WORD  = L_WORD_DEF,
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 10,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Ready,
    input  logic [2*L_WORD-1:0]   final_product,
    input  logic                  clear,
    input  logic                  acc_ack,
    output logic [ACC_W-1:0]      acc_out,
    output logic                  acc_valid,
    output logic [CNT_W-1:0]      term_count,
    output logic                  overflow,
    output logic                  overrun,
    output logic                  busy
);

    localparam int PROD_W = prod_width(L_WORD);
    localparam int SUM_W  = ACC_W + 1;

    logic cmpl;

    ready_edge_detect u_ready_edge (
        .clk     (clk),
        .rst     (rst),
        .ready_i (Ready),
        .cmpl_o  (cmpl)
    );

    acc_state_e        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PROD_W-1:0] pend_q, pend_d;
    logic              pend_v_q, pend_v_d;
    logic              ovf_q, ovf_d;
    logic              ovr_q, ovr_d;

    // One shared adder. In ACCUM it extends the running sum; on an ack in
    // HOLD it seeds the next sum from the pending entry instead.
    logic [ACC_W-1:0] add_a, add_b;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] cnt_inc;

    assign add_a   = (state_q == HOLD) ? (pend_v_q ? ACC_W'(pend_q) : '0) : acc_q;
    assign add_b   = cmpl ? ACC_W'(final_product) : '0;
    assign sum     = {1'b0, add_a} + {1'b0, add_b};
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path through
        // the case/if tree leaves one unassigned and infers a latch.
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        ovf_d    = ovf_q;
        ovr_d    = ovr_q;

        if (clear) begin
            // A completion in the same cycle is discarded along with the sum.
            state_d  = ACCUM;
            acc_d    = '0;
            cnt_d    = '0;
            pend_v_d = 1'b0;
            ovf_d    = 1'b0;
            ovr_d    = 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (cmpl) begin
                        acc_d = sum[ACC_W-1:0];
                        cnt_d = cnt_inc;
                        if (sum[ACC_W]) begin
                            ovf_d = 1'b1;
                        end
                        if (cnt_inc == CNT_W'(N_TERMS)) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (acc_ack) begin
                        // Pending product and a simultaneous completion both
                        // start the next sum; N_TERMS >= 3 so this never
                        // completes a sum on its own.
                        state_d  = ACCUM;
                        acc_d    = sum[ACC_W-1:0];
                        cnt_d    = CNT_W'(pend_v_q) + CNT_W'(cmpl);
                        pend_v_d = 1'b0;
                        if (sum[ACC_W]) begin
                            ovf_d = 1'b1;
                        end
                    end else if (cmpl) begin
                        if (!pend_v_q) begin
                            pend_d   = final_product;
                            pend_v_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ACCUM;
            acc_q    <= '0;
            cnt_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            ovf_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            ovf_q    <= ovf_d;
            ovr_q    <= ovr_d;
        end
    end

    assign acc_out    = acc_q;
    assign acc_valid  = (state_q == HOLD);
    assign term_count = cnt_q;
    assign overflow   = ovf_q;
    assign overrun    = ovr_q;
    assign busy       = (cnt_q != '0) | acc_valid;

endmodule : mult_dot_accumulator

// File: tb/tb_mult_dot_accumulator.sv
// -----------------------------------------------------------------------------
// tb_mult_dot_accumulator
// Self-checking bench: directed vector table, hand-written overflow and
// mid-sum reset sequences, then randomized traffic against a behavioural model
// that tracks the true (unbounded) sum of the products in the current term.
// -----------------------------------------------------------------------------
module tb_mult_dot_accumulator;

    localparam int L_WORD  = 4;
    localparam int N_TERMS = 4;
    localparam int ACC_W   = 10;
    localparam int CNT_W   = 8;
    localparam longint MOD = longint'(1) << ACC_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             Ready;
    logic [7:0]       final_product;
    logic             clear;
    logic             acc_ack;
    logic [ACC_W-1:0] acc_out;
    logic             acc_valid;
    logic [CNT_W-1:0] term_count;
    logic             overflow, overrun, busy;

    // Narrow-accumulator instance sharing the stimulus, used for the wrap test.
    logic [7:0]       acc_out8;
    logic             acc_valid8;
    logic [CNT_W-1:0] term_count8;
    logic             overflow8, overrun8, busy8;

    mult_dot_accumulator #(.L_WORD(L_WORD), .N_TERMS(N_TERMS), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .Ready(Ready), .final_product(final_product),
        .clear(clear), .acc_ack(acc_ack), .acc_out(acc_out), .acc_valid(acc_valid),
        .term_count(term_count), .overflow(overflow), .overrun(overrun), .busy(busy)
    );

    mult_dot_accumulator #(.L_WORD(L_WORD), .N_TERMS(N_TERMS), .ACC_W(8), .CNT_W(CNT_W)) dut8 (
        .clk(clk), .rst(rst), .Ready(Ready), .final_product(final_product),
        .clear(clear), .acc_ack(acc_ack), .acc_out(acc_out8), .acc_valid(acc_valid8),
        .term_count(term_count8), .overflow(overflow8), .overrun(overrun8), .busy(busy8)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint m_acc;      // true sum of the products in the current term
    int     m_cnt;
    bit     m_hold, m_ovf, m_ovr, m_prev;
    int     m_pend[$];

    task automatic model_reset();
        m_acc = 0; m_cnt = 0; m_hold = 0; m_ovf = 0; m_ovr = 0; m_prev = 1;
        m_pend.delete();
    endtask

    task automatic model_step(input bit rdy, input int prod, input bit ack, input bit clr, input bit rs);
        bit c;
        if (rs) begin
            model_reset();
            return;
        end
        c = rdy && !m_prev;
        m_prev = rdy;
        if (clr) begin
            m_acc = 0; m_cnt = 0; m_hold = 0; m_ovf = 0; m_ovr = 0;
            m_pend.delete();
            return;
        end
        if (!m_hold) begin
            if (c) begin
                m_acc += prod;
                m_cnt++;
                if (m_cnt == N_TERMS) m_hold = 1;
            end
        end else if (ack) begin
            m_hold = 0;
            m_acc = 0;
            m_cnt = 0;
            foreach (m_pend[i]) begin m_acc += m_pend[i]; m_cnt++; end
            if (c) begin m_acc += prod; m_cnt++; end
            m_pend.delete();
        end else if (c) begin
            if (m_pend.size() == 0) m_pend.push_back(prod);
            else m_ovr = 1;
        end
        if (m_acc >= MOD) m_ovf = 1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".acc_out"},    acc_out,    32'(m_acc % MOD));
        check({tag, ".acc_valid"},  acc_valid,  32'(m_hold));
        check({tag, ".term_count"}, term_count, 32'(m_cnt));
        check({tag, ".overflow"},   overflow,   32'(m_ovf));
        check({tag, ".overrun"},    overrun,    32'(m_ovr));
        check({tag, ".busy"},       busy,       32'(m_cnt != 0 || m_hold));
    endtask

    // ---------------- stimulus primitives ----------------
    // Drive one cycle of inputs, let the edge sample them, then settle #1.
    task automatic step(input bit rdy, input int prod, input bit ack, input bit clr, input bit rs);
        Ready = rdy; final_product = 8'(prod); acc_ack = ack; clear = clr; rst = rs;
        @(posedge clk);
        model_step(rdy, prod, ack, clr, rs);
        #1;
    endtask

    // Multiplier-like completion: Ready low for 3 cycles, then high with the product.
    task automatic send_product(input int p, input bit ack_on_cmpl);
        for (int i = 0; i < 3; i++) step(0, $urandom_range(255), 0, 0, 0);
        step(1, p, ack_on_cmpl, 0, 0);
    endtask

    typedef enum {K_PROD, K_IDLE, K_ACK, K_ACKPROD, K_CLR} kind_e;
    typedef struct {
        kind_e kind;
        int    val;
        int    exp_acc;
        bit    exp_valid;
        int    exp_cnt;
        bit    exp_ovr;
    } vec_t;

    vec_t vecs[21];

    initial begin
        vecs = '{
            '{K_PROD,    6,   6, 0, 1, 0},
            '{K_PROD,   15,  21, 0, 2, 0},
            '{K_PROD,    0,  21, 0, 3, 0},
            '{K_PROD,  225, 246, 1, 4, 0},
            '{K_IDLE,    6, 246, 1, 4, 0},
            '{K_PROD,    7, 246, 1, 4, 0},
            '{K_ACK,     0,   7, 0, 1, 0},
            '{K_PROD,    1,   8, 0, 2, 0},
            '{K_PROD,    1,   9, 0, 3, 0},
            '{K_PROD,    1,  10, 1, 4, 0},
            '{K_PROD,    7,  10, 1, 4, 0},
            '{K_PROD,    9,  10, 1, 4, 1},
            '{K_ACK,     0,   7, 0, 1, 1},
            '{K_CLR,     0,   0, 0, 0, 0},
            '{K_PROD,    1,   1, 0, 1, 0},
            '{K_PROD,    2,   3, 0, 2, 0},
            '{K_PROD,    3,   6, 0, 3, 0},
            '{K_PROD,    4,  10, 1, 4, 0},
            '{K_ACKPROD,12,  12, 0, 1, 0},
            '{K_ACK,     0,  12, 0, 1, 0},
            '{K_CLR,     0,   0, 0, 0, 0}
        };

        model_reset();
        Ready = 1; final_product = 0; acc_ack = 0; clear = 0; rst = 1;

        // Reset with Ready held high: nothing counted, everything zero.
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        check("reset.acc_out",    acc_out,    0);
        check("reset.acc_valid",  acc_valid,  0);
        check("reset.term_count", term_count, 0);
        check("reset.overflow",   overflow,   0);
        check("reset.overrun",    overrun,    0);
        check("reset.busy",       busy,       0);

        // Directed vector table.
        for (int v = 0; v < 21; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            case (vecs[v].kind)
                K_PROD:    send_product(vecs[v].val, 0);
                K_IDLE:    for (int i = 0; i < vecs[v].val; i++) step(1, 0, 0, 0, 0);
                K_ACK:     step(1, 0, 1, 0, 0);
                K_ACKPROD: send_product(vecs[v].val, 1);
                K_CLR:     step(1, 0, 0, 1, 0);
                default:   ;
            endcase
            check({tag, ".acc_out"},    acc_out,    vecs[v].exp_acc);
            check({tag, ".acc_valid"},  acc_valid,  vecs[v].exp_valid);
            check({tag, ".term_count"}, term_count, vecs[v].exp_cnt);
            check({tag, ".overrun"},    overrun,    vecs[v].exp_ovr);
            check({tag, ".overflow"},   overflow,   0);
            check({tag, ".busy"},       busy,       (vecs[v].exp_cnt != 0) || vecs[v].exp_valid);
        end

        // Wrap test on the 8-bit accumulator (both instances were just cleared).
        send_product(225, 0);
        send_product(225, 0);
        check("ovf8.acc_out",    acc_out8,    194);
        check("ovf8.overflow",   overflow8,   1);
        check("ovf8.term_count", term_count8, 2);
        check("ovf10.acc_out",   acc_out,     450);
        send_product(1, 0);
        send_product(1, 0);
        check("ovf8.final_acc",   acc_out8,   196);
        check("ovf8.final_valid", acc_valid8, 1);
        check("ovf8.sticky",      overflow8,  1);
        check("ovf10.final_acc",  acc_out,    452);
        check("ovf10.overflow",   overflow,   0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0);
        check("ovf8.cleared", overflow8, 0);

        // Reset in the middle of a sum, Ready held high across it.
        send_product(5, 0);
        send_product(6, 0);
        check("midrst.pre_cnt", term_count, 2);
        step(1, 0, 0, 0, 1);
        check("midrst.acc_out",    acc_out,    0);
        check("midrst.term_count", term_count, 0);
        check("midrst.busy",       busy,       0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("midrst.no_spurious", term_count, 0);
        send_product(1, 0);
        send_product(2, 0);
        send_product(3, 0);
        send_product(4, 0);
        check("midrst.sum",   acc_out,    10);
        check("midrst.valid", acc_valid,  1);
        check("midrst.cnt",   term_count, 4);
        step(1, 0, 1, 0, 0);
        check_model("midrst.model");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            int gap, hi, p;
            gap = $urandom_range(6, 3);
            hi  = $urandom_range(3, 1);
            p   = $urandom_range(255);
            for (int i = 0; i < gap; i++) begin
                step(0, $urandom_range(255), ($urandom_range(3) == 0), ($urandom_range(200) == 0), 0);
                check_model("rand");
            end
            for (int i = 0; i < hi; i++) begin
                step(1, (i == 0) ? p : $urandom_range(255), ($urandom_range(3) == 0), 0, 0);
                check_model("rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mult_dot_accumulator

// File: doc/mult_dot_accumulator.md
# mult_dot_accumulator

Downstream consumer of the sequential multiplier. It watches the multiplier's `Ready` flag, captures `final_product` on every completed multiplication, and sums `N_TERMS` consecutive products into a dot-product result. The result is presented on a valid/ack handshake with a one-entry pending buffer, so the multiplier never has to stall. It sits between the multiplier and the system result bus.

## Interface
- `L_WORD`, 4, multiplier operand width; products are 2*L_WORD bits.
- `N_TERMS`, 4, products per dot-product; legal range 3..255.
- `ACC_W`, 10, accumulator width; must be ≥ 2*L_WORD.
- `CNT_W`, 8, term-counter width; must hold N_TERMS.

Ports:
- `clk` in 1: single clock; all state changes on posedge.
- `rst` in 1: synchronous, active-high reset; one clock, reset synchronous active-high.
- `Ready` in 1: multiplier ready flag; a 0→1 transition marks a completed product.
- `final_product` in 2*L_WORD: multiplier result; valid in the cycle `Ready` is first seen high.
- `clear` in 1: synchronous abort of the current accumulation.
- `acc_ack` in 1: consumer accepts `acc_out`.
- `acc_out` out ACC_W: dot-product result; held stable while `acc_valid`.
- `acc_valid` out 1: result available.
- `term_count` out CNT_W: products accumulated in the current sum.
- `overflow` out 1: sticky; the accumulator wrapped.
- `overrun` out 1: sticky; a product was dropped.
- `busy` out 1: term_count ≠ 0 or acc_valid.

## Operation
- Completion detect: `rdy_d` is a register of `Ready` that resets to 1. `cmpl = Ready & ~rdy_d`. Constant-high `Ready` (idle or reset) produces no completions.
- States: ACCUM and HOLD, with reset state ACCUM.
- ACCUM, on `cmpl`:
  - `acc <= acc + final_product`, zero-extended and wrapping modulo 2^ACC_W.
  - A carry out of bit ACC_W-1 sets `overflow`.
  - `term_count` increments.
  - When the increment reaches N_TERMS, go to HOLD with `acc_valid=1` and `term_count=N_TERMS`.
- HOLD:
  - `acc_out` and `term_count` are frozen.
  - `cmpl` with pending empty: store the product in `pend`, set `pend_v`.
  - `cmpl` with pending full: discard the product, set `overrun`.
  - `acc_ack`: drop `acc_valid` and return to ACCUM. The new sum is (pend_v ? pend : 0) + (cmpl ? final_product : 0), and the new `term_count` is pend_v + cmpl. `pend_v` clears.
  - `acc_ack` while in ACCUM is ignored.
- Priority: `rst` > `clear` > everything else.
- `clear` zeroes `acc`, `term_count`, `pend_v`, `acc_valid`, `overflow` and `overrun`, and forces ACCUM. A `cmpl` in the same cycle is discarded. `rdy_d` still tracks `Ready`.
- Reset mid-sum: everything is lost. Because `rdy_d` resets to 1, the multiplier's reset-time `Ready=1` is not counted.

## Timing
- Reset values:
  - `acc_out`=0, `acc_valid`=0, `term_count`=0.
  - `overflow`=0, `overrun`=0, `busy`=0.
  - `rdy_d`=1, `pend_v`=0.
- Latency: `final_product` is added on the same edge that ends the cycle in which `cmpl`=1. With the multiplier's registered `Ready`, that is one clock after the multiplier's latch edge.
- `acc_valid` rises on the edge that adds the N_TERMS-th product. It stays high until the edge that samples `acc_ack`=1.
- `acc_ack` and `cmpl` in the same HOLD cycle: both are honoured as above, and nothing is lost.
- Completions can be no closer than the multiplier's minimum operation period (≥4 cycles), so one pending entry covers one ack delay of that length.

## Structure
- Shared package/header `mult_pkg` holds:
  - state localparams ACCUM=1'b0, HOLD=1'b1;
  - default L_WORD, shared with the multiplier;
  - derived widths 2*L_WORD.
- One sub-module, `ready_edge_detect`: the `rdy_d` register (reset value 1) plus the `cmpl` output. The multiplier-side wrapper can reuse it.
- The rest (accumulator, counter, pending register, FSM) lives in the top; roughly 150–200 RTL lines.

## Test plan
- Basic sum: products 6, 15, 0, 225 arrive via Ready pulses → `acc_out`=246, `acc_valid`=1, `term_count`=4. Ack → `acc_valid`=0, `term_count`=0.
- Backpressure: with `acc_valid` held 6 cycles, product 7 arrives → `acc_out` stays 246, `overrun`=0. Ack → `acc_out`=7, `term_count`=1.
- Overrun: in HOLD, products 7 and 9 arrive with no ack → second is dropped, `overrun`=1. After ack the sum starts at 7. `clear` → `overrun`=0.
- Overflow (ACC_W=8): products 225, 225 → `acc`=194, `overflow`=1. Continue with 1, 1 → `acc_out`=196, `acc_valid`=1.
- Simultaneous ack and completion in HOLD, pending empty, product 12 → next `term_count`=1, `acc`=12, no loss.
- Mid-operation: after 2 of 4 products, pulse `rst` (Ready held 1 through reset) → all outputs 0. The next 4 products give a fresh sum with no spurious term.
